// File: rtl/tow_round_ctrl_if.sv
// rtl/tow_round_ctrl_if.sv - player keys and playfield/score bundle for tow_round_ctrl
interface tow_round_ctrl_if #(
   parameter int NUM_LIGHTS = 9,
   parameter int SCORE_MAX  = 7
);
   localparam int SW = $clog2(SCORE_MAX + 1);

   logic                  L;
   logic                  R;
   logic [NUM_LIGHTS-1:0] lights;
   logic [SW-1:0]         l_score;
   logic [SW-1:0]         r_score;
   logic [1:0]            winner;
   logic                  round_start;
   logic                  match_over;

   modport master (
      output L,
      output R,
      input  lights,
      input  l_score,
      input  r_score,
      input  winner,
      input  round_start,
      input  match_over
   );

   modport slave (
      input  L,
      input  R,
      output lights,
      output l_score,
      output r_score,
      output winner,
      output round_start,
      output match_over
   );
endinterface

// File: rtl/tow_round_ctrl.sv
// rtl/tow_round_ctrl.sv - tug-of-war referee: key presses to light moves, round wins, scores, match end
module tow_round_ctrl #(
   parameter int NUM_LIGHTS  = 9,
   parameter int SCORE_MAX   = 7,
   parameter int HOLD_CYCLES = 4
) (
   input  logic               clk,
   input  logic               Reset,
   tow_round_ctrl_if.slave    bus
);
   localparam int SW = $clog2(SCORE_MAX + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [1:0] PLAY       = 2'd0;
   localparam logic [1:0] WIN_HOLD   = 2'd1;
   localparam logic [1:0] MATCH_OVER = 2'd2;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b10;
   localparam logic [1:0] WIN_RIGHT = 2'b01;

   localparam logic [NUM_LIGHTS-1:0] LIGHTS_OFF    = '0;
   localparam logic [NUM_LIGHTS-1:0] CENTRE_ONEHOT =
      {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << (NUM_LIGHTS / 2);

   localparam logic [SW-1:0] SCORE_ZERO = '0;
   localparam logic [SW-1:0] SCORE_ONE  = SW'(1);
   localparam logic [SW-1:0] SCORE_TOP  = SW'(SCORE_MAX);
   localparam logic [HW-1:0] HOLD_ZERO  = '0;
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

   logic [1:0]            state_q,       state_d;
   logic [NUM_LIGHTS-1:0] lights_q,      lights_d;
   logic [SW-1:0]         l_score_q,     l_score_d;
   logic [SW-1:0]         r_score_q,     r_score_d;
   logic [1:0]            winner_q,      winner_d;
   logic                  round_start_q, round_start_d;
   logic                  match_over_q,  match_over_d;
   logic [HW-1:0]         hold_q,        hold_d;
   logic                  l_prev_q;
   logic                  r_prev_q;

   logic                  lp;
   logic                  rp;
   logic [SW-1:0]         win_score;

   assign lp = bus.L & ~l_prev_q;
   assign rp = bus.R & ~r_prev_q;
   assign win_score = (winner_q == WIN_LEFT) ? l_score_q : r_score_q;

   always_comb begin
      state_d       = state_q;
      lights_d      = lights_q;
      l_score_d     = l_score_q;
      r_score_d     = r_score_q;
      winner_d      = winner_q;
      round_start_d = 1'b0;
      match_over_d  = match_over_q;
      hold_d        = hold_q;

      case (state_q)
         PLAY: begin
            if (lp && !rp) begin
               if (lights_q[NUM_LIGHTS-1]) begin
                  if (l_score_q != SCORE_TOP) begin
                     l_score_d = l_score_q + SCORE_ONE;
                  end
                  winner_d = WIN_LEFT;
                  lights_d = LIGHTS_OFF;
                  hold_d   = HOLD_LOAD;
                  state_d  = WIN_HOLD;
               end else begin
                  lights_d = lights_q << 1;
               end
            end else if (rp && !lp) begin
               if (lights_q[0]) begin
                  if (r_score_q != SCORE_TOP) begin
                     r_score_d = r_score_q + SCORE_ONE;
                  end
                  winner_d = WIN_RIGHT;
                  lights_d = LIGHTS_OFF;
                  hold_d   = HOLD_LOAD;
                  state_d  = WIN_HOLD;
               end else begin
                  lights_d = lights_q >> 1;
               end
            end
         end

         // Counter was loaded with HOLD_CYCLES-1 on entry, so zero here is the HOLD_CYCLES-th edge.
         WIN_HOLD: begin
            if (hold_q == HOLD_ZERO) begin
               if (win_score == SCORE_TOP) begin
                  match_over_d = 1'b1;
                  state_d      = MATCH_OVER;
               end else begin
                  lights_d      = CENTRE_ONEHOT;
                  winner_d      = WIN_NONE;
                  round_start_d = 1'b1;
                  state_d       = PLAY;
               end
            end else begin
               hold_d = hold_q - HOLD_ONE;
            end
         end

         MATCH_OVER: begin
            lights_d = LIGHTS_OFF;
         end

         default: begin
            state_d  = PLAY;
            lights_d = CENTRE_ONEHOT;
            winner_d = WIN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // Key history loads in reset too, so a key held through reset is not a press.
      l_prev_q <= bus.L;
      r_prev_q <= bus.R;
      if (Reset) begin
         state_q       <= PLAY;
         lights_q      <= CENTRE_ONEHOT;
         l_score_q     <= SCORE_ZERO;
         r_score_q     <= SCORE_ZERO;
         winner_q      <= WIN_NONE;
         round_start_q <= 1'b0;
         match_over_q  <= 1'b0;
         hold_q        <= HOLD_ZERO;
      end else begin
         state_q       <= state_d;
         lights_q      <= lights_d;
         l_score_q     <= l_score_d;
         r_score_q     <= r_score_d;
         winner_q      <= winner_d;
         round_start_q <= round_start_d;
         match_over_q  <= match_over_d;
         hold_q        <= hold_d;
      end
   end

   assign bus.lights      = lights_q;
   assign bus.l_score     = l_score_q;
   assign bus.r_score     = r_score_q;
   assign bus.winner      = winner_q;
   assign bus.round_start = round_start_q;
   assign bus.match_over  = match_over_q;

endmodule
